// File: rtl/pc_ir_unit_pkg.sv
// Shared types for the PC/IR datapath and its memory handshake.
package pc_ir_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_HOLD   = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        HS_IDLE = 2'b00,
        HS_WAIT = 2'b01,
        HS_DONE = 2'b10
    } hs_state_e;

    // Pseudo-direct jump: keep the PC's top nibble, word-align the 26-bit field.
    function automatic word_t jump_target(input word_t pc, input word_t instr);
        return {pc[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/pc_ir_unit_mem_handshake.sv
// Memory request handshake: IDLE/WAIT/DONE sequencing, wait counter and
// sticky timeout flag for the PC/IR unit.
module mem_handshake
    import pc_ir_unit_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic access_i,
    input  logic mem_ready_i,
    output logic mem_req_o,
    output logic busy_o,
    output logic capture_o,
    output logic err_timeout_o
);

    localparam int unsigned CNT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

    hs_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // The request is combinational so a ready memory can answer in the IDLE cycle;
    // it is gated by reset so nothing is requested while the unit is held.
    assign mem_req_o     = rst_ni & access_i & (state_q != HS_DONE);
    assign capture_o     = mem_req_o & mem_ready_i;
    assign busy_o        = access_i & (state_q != HS_DONE) & ~capture_o;
    assign err_timeout_o = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HS_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                HS_IDLE: begin
                    cnt_q <= '0;
                    if (access_i) begin
                        state_q <= mem_ready_i ? HS_DONE : HS_WAIT;
                    end
                end
                HS_WAIT: begin
                    if (!access_i) begin
                        state_q <= HS_IDLE;
                        cnt_q   <= '0;
                    end else if (mem_ready_i) begin
                        state_q <= HS_DONE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= HS_DONE;
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HS_DONE: begin
                    state_q <= HS_IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= HS_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pc_ir_unit.sv
// Multicycle PC/IR datapath slice: PC, IR, MDR and ALU-out registers plus the
// next-PC mux, with memory accesses sequenced by mem_handshake.
module pc_ir_unit
    import pc_ir_unit_pkg::*;
#(
    parameter word_t       RESET_PC     = 32'h0000_0000,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        PCWrite_i,
    input  logic        isBranch_i,
    input  logic        IRWrite_i,
    input  logic        lorD_i,
    input  logic        MemWrite_i,
    input  logic [1:0]  PCSource_i,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic [31:0] mdr_o,
    output logic [31:0] alu_out_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        busy_o,
    output logic        err_timeout_o
);

    word_t  pc_q, pc_d;
    word_t  instr_q, instr_d;
    word_t  mdr_q, mdr_d;
    word_t  alu_out_q, alu_out_d;
    logic   access, pc_en, busy, capture, mem_req;
    pcsrc_e pc_sel;

    assign access = IRWrite_i | lorD_i | MemWrite_i;
    assign pc_en  = PCWrite_i | (isBranch_i & alu_zero_i);
    assign pc_sel = pcsrc_e'(PCSource_i);

    mem_handshake #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_handshake (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .access_i      (access),
        .mem_ready_i   (mem_ready_i),
        .mem_req_o     (mem_req),
        .busy_o        (busy),
        .capture_o     (capture),
        .err_timeout_o (err_timeout_o)
    );

    // Every register holds while the access is outstanding, so a fetch that
    // waits updates PC and IR together on the edge the memory answers.
    always_comb begin
        pc_d = pc_q;
        if (pc_en && !busy) begin
            case (pc_sel)
                PCSRC_ALU:    pc_d = alu_result_i;
                PCSRC_ALUOUT: pc_d = alu_out_q;
                PCSRC_JUMP:   pc_d = jump_target(pc_q, instr_q);
                default:      pc_d = pc_q;
            endcase
        end
        instr_d   = (capture && IRWrite_i) ? mem_rdata_i : instr_q;
        mdr_d     = (capture && lorD_i && !MemWrite_i) ? mem_rdata_i : mdr_q;
        alu_out_d = busy ? alu_out_q : alu_result_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            mdr_q     <= '0;
            alu_out_q <= '0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            mdr_q     <= mdr_d;
            alu_out_q <= alu_out_d;
        end
    end

    assign pc_o       = pc_q;
    assign instr_o    = instr_q;
    assign mdr_o      = mdr_q;
    assign alu_out_o  = alu_out_q;
    assign mem_addr_o = lorD_i ? alu_out_q : pc_q;
    assign mem_req_o  = mem_req;
    assign mem_we_o   = mem_req & MemWrite_i;
    assign busy_o     = busy;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed bench for pc_ir_unit: a cycle-level reference model checked on every
// falling edge, plus literal expectations for the worked scenarios.
module tb_pc_ir_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          WAIT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCWrite, isBranch, IRWrite, lorD, MemWrite;
    logic [1:0]  PCSource;
    logic [31:0] alu_result, mem_rdata;
    logic        alu_zero, mem_ready;
    logic [31:0] pc, instr, mdr, alu_out, mem_addr;
    logic        mem_req, mem_we, busy, err_timeout;

    int vecCount = 0;
    int errCount = 0;

    logic [31:0] mPc, mInstr, mMdr, mAluOut, mNextPc;
    logic        mErr, mCool, mAcc, mReq, mAns, mBusy;
    int          mWaited;

    logic        sBusy, sReq, sWe;
    logic [31:0] sAddr;
    int          busyCycles;

    pc_ir_unit #(
        .RESET_PC     (RESET_PC),
        .MEM_WAIT_MAX (WAIT_MAX)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .PCWrite_i     (PCWrite),
        .isBranch_i    (isBranch),
        .IRWrite_i     (IRWrite),
        .lorD_i        (lorD),
        .MemWrite_i    (MemWrite),
        .PCSource_i    (PCSource),
        .alu_result_i  (alu_result),
        .alu_zero_i    (alu_zero),
        .mem_rdata_i   (mem_rdata),
        .mem_ready_i   (mem_ready),
        .pc_o          (pc),
        .instr_o       (instr),
        .mdr_o         (mdr),
        .alu_out_o     (alu_out),
        .mem_addr_o    (mem_addr),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .busy_o        (busy),
        .err_timeout_o (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // One controller cycle: drive strobes, sample the combinational outputs, cross one edge.
    task automatic applyStimulus(input logic pcw, input logic br, input logic irw, input logic iord,
                                 input logic memw, input logic [1:0] src, input logic [31:0] res,
                                 input logic zero, input logic [31:0] rdata, input logic ready);
        PCWrite = pcw; isBranch = br; IRWrite = irw; lorD = iord; MemWrite = memw;
        PCSource = src; alu_result = res; alu_zero = zero; mem_rdata = rdata; mem_ready = ready;
        #1;
        sBusy = busy; sReq = mem_req; sWe = mem_we; sAddr = mem_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle(input logic [31:0] res, input logic ready);
        applyStimulus(0, 0, 0, 0, 0, 2'b00, res, 0, 32'h0, ready);
    endtask

    // Reference model: an outstanding request is answered, or abandoned after
    // WAIT_MAX unanswered wait cycles; either way one quiet cycle follows.
    always @(negedge clk) begin
        if (!rst_n) begin
            mPc = RESET_PC; mInstr = '0; mMdr = '0; mAluOut = '0;
            mErr = 1'b0; mCool = 1'b0; mWaited = 0;
        end
        mAcc  = IRWrite | lorD | MemWrite;
        mReq  = rst_n && mAcc && !mCool;
        mAns  = mReq && mem_ready;
        mBusy = mAcc && !mCool && !mAns;

        checkOutput("pc", pc, mPc);
        checkOutput("instr", instr, mInstr);
        checkOutput("mdr", mdr, mMdr);
        checkOutput("alu_out", alu_out, mAluOut);
        checkOutput("mem_addr", mem_addr, lorD ? mAluOut : mPc);
        checkOutput("mem_req", {31'b0, mem_req}, {31'b0, mReq});
        checkOutput("mem_we", {31'b0, mem_we}, {31'b0, mReq && MemWrite});
        checkOutput("busy", {31'b0, busy}, {31'b0, mBusy});
        checkOutput("err_timeout", {31'b0, err_timeout}, {31'b0, mErr});

        if (rst_n) begin
            mNextPc = mPc;
            if ((PCWrite || (isBranch && alu_zero)) && !mBusy) begin
                case (PCSource)
                    2'b00:   mNextPc = alu_result;
                    2'b01:   mNextPc = mAluOut;
                    2'b10:   mNextPc = {mPc[31:28], mInstr[25:0], 2'b00};
                    default: mNextPc = mPc;
                endcase
            end
            mPc = mNextPc;
            if (mAns && IRWrite) mInstr = mem_rdata;
            if (mAns && lorD && !MemWrite) mMdr = mem_rdata;
            if (!mBusy) mAluOut = alu_result;
            if (mCool) begin
                mCool = 1'b0; mWaited = 0;
            end else if (mAns) begin
                mCool = 1'b1; mWaited = 0;
            end else if (mReq) begin
                if (mWaited == WAIT_MAX) begin
                    mErr = 1'b1; mCool = 1'b1; mWaited = 0;
                end else begin
                    mWaited++;
                end
            end else begin
                mWaited = 0;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        PCWrite = 0; isBranch = 0; IRWrite = 0; lorD = 0; MemWrite = 0;
        PCSource = 2'b00; alu_result = '0; alu_zero = 0; mem_rdata = '0; mem_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checkOutput("reset_pc", pc, RESET_PC);
        checkOutput("reset_instr", instr, 32'h0);
        idleCycle(32'h0, 0);

        // Fetch answered in the same cycle.
        applyStimulus(1, 0, 1, 0, 0, 2'b00, 32'h4, 0, 32'h8C01_0004, 1);
        checkOutput("fetch0_busy", {31'b0, sBusy}, 32'h0);
        idleCycle(32'h0, 0);
        checkOutput("fetch0_pc", pc, 32'h4);
        checkOutput("fetch0_instr", instr, 32'h8C01_0004);

        // Fetch answered after three waiting cycles; access held into DONE is not re-issued.
        busyCycles = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 1, 0, 0, 2'b00, 32'h8, 0, 32'h1111_1111, 0);
            if (sBusy) busyCycles++;
        end
        checkOutput("fetch3_pc_held", pc, 32'h4);
        applyStimulus(1, 0, 1, 0, 0, 2'b00, 32'h8, 0, 32'h2402_0008, 1);
        if (sBusy) busyCycles++;
        checkOutput("fetch3_busy_cycles", busyCycles, 32'd3);
        checkOutput("fetch3_pc", pc, 32'h8);
        checkOutput("fetch3_instr", instr, 32'h2402_0008);
        applyStimulus(0, 0, 1, 0, 0, 2'b00, 32'h0, 0, 32'h3333_3333, 1);
        checkOutput("done_req", {31'b0, sReq}, 32'h0);
        checkOutput("done_instr", instr, 32'h2402_0008);
        idleCycle(32'h40, 0);

        // Branch via alu_out, taken then not taken; dual strobe; hold select.
        applyStimulus(0, 1, 0, 0, 0, 2'b01, 32'h99, 1, 32'h0, 0);
        checkOutput("branch_taken_pc", pc, 32'h40);
        applyStimulus(0, 1, 0, 0, 0, 2'b01, 32'h77, 0, 32'h0, 0);
        checkOutput("branch_not_taken_pc", pc, 32'h40);
        applyStimulus(1, 1, 0, 0, 0, 2'b00, 32'h44, 1, 32'h0, 0);
        checkOutput("branch_and_write_pc", pc, 32'h44);
        applyStimulus(1, 0, 0, 0, 0, 2'b11, 32'h88, 0, 32'h0, 0);
        checkOutput("hold_pc", pc, 32'h44);

        // Jump keeps the upper nibble of PC.
        applyStimulus(1, 0, 0, 0, 0, 2'b00, 32'h1000_0008, 0, 32'h0, 0);
        applyStimulus(0, 0, 1, 0, 0, 2'b00, 32'h0, 0, 32'h0800_0010, 1);
        idleCycle(32'h0, 0);
        applyStimulus(1, 0, 0, 0, 0, 2'b10, 32'h0, 0, 32'h0, 0);
        checkOutput("jump_pc", pc, 32'h1000_0040);
        applyStimulus(1, 0, 0, 0, 0, 2'b00, 32'hFFFF_FFFC, 0, 32'h0, 0);
        applyStimulus(1, 0, 0, 0, 0, 2'b10, 32'h0, 0, 32'h0, 0);
        checkOutput("jump_high_pc", pc, 32'hF000_0040);

        // Load through alu_out, then a store that captures nothing.
        idleCycle(32'h20, 0);
        applyStimulus(0, 0, 0, 1, 0, 2'b00, 32'h20, 0, 32'hDEAD_BEEF, 0);
        checkOutput("load_addr", sAddr, 32'h20);
        applyStimulus(0, 0, 0, 1, 0, 2'b00, 32'h20, 0, 32'hDEAD_BEEF, 1);
        checkOutput("load_mdr", mdr, 32'hDEAD_BEEF);
        idleCycle(32'h20, 0);
        applyStimulus(0, 0, 0, 1, 1, 2'b00, 32'h20, 0, 32'h5555_5555, 1);
        checkOutput("store_we", {31'b0, sWe}, 32'h1);
        idleCycle(32'h20, 0);
        checkOutput("store_mdr", mdr, 32'hDEAD_BEEF);

        // Load never answered: one request cycle plus WAIT_MAX wait cycles.
        for (int i = 0; i < WAIT_MAX; i++) begin
            applyStimulus(0, 0, 0, 1, 0, 2'b00, 32'h20, 0, 32'h6666_6666, 0);
        end
        checkOutput("timeout_early", {31'b0, err_timeout}, 32'h0);
        applyStimulus(0, 0, 0, 1, 0, 2'b00, 32'h20, 0, 32'h6666_6666, 0);
        checkOutput("timeout_set", {31'b0, err_timeout}, 32'h1);
        checkOutput("timeout_mdr", mdr, 32'hDEAD_BEEF);
        idleCycle(32'h0, 0);
        idleCycle(32'h0, 0);
        checkOutput("timeout_sticky", {31'b0, err_timeout}, 32'h1);

        // Reset in the middle of a waiting fetch; late ready pulses are ignored.
        applyStimulus(1, 0, 1, 0, 0, 2'b00, 32'h4, 0, 32'hBAD0_BAD0, 0);
        applyStimulus(1, 0, 1, 0, 0, 2'b00, 32'h4, 0, 32'hBAD0_BAD0, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_req", {31'b0, mem_req}, 32'h0);
        checkOutput("rst_pc", pc, RESET_PC);
        applyStimulus(1, 0, 1, 0, 0, 2'b00, 32'h4, 0, 32'hBAD0_BAD0, 1);
        checkOutput("rst_req_ready", {31'b0, sReq}, 32'h0);
        idleCycle(32'h0, 0);
        rst_n = 1'b1;
        idleCycle(32'h0, 1);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_pc_after", pc, RESET_PC);
        checkOutput("rst_err", {31'b0, err_timeout}, 32'h0);
        applyStimulus(1, 0, 1, 0, 0, 2'b00, 32'h4, 0, 32'h1234_5678, 1);
        checkOutput("post_rst_busy", {31'b0, sBusy}, 32'h0);
        idleCycle(32'h0, 0);
        checkOutput("post_rst_instr", instr, 32'h1234_5678);
        checkOutput("post_rst_pc", pc, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
